cpu_sequencer: RTL and testbench
================================

// Module: cpu_sequencer
// PURPOSE
//  Multi-cycle control FSM for the 16-bit core: fetches from imem, holds the IR that feeds the
//  instruction decoder, and sequences execute, data memory and writeback.
//  Gates the decoder's RegWrite/MemWrite so each takes effect exactly once per instruction.
//  Owns the PC, branch resolution (opcodes 1011/1100), halt and the retired-instruction count.
// PARAMETERS
//  PC_W      8      PC / imem address width
//  RESET_PC  0      PC value loaded on reset and on start
//  CNT_W     16     retired-instruction counter width (saturating)
// PORTS
//  clk           in   1      single clock; all state on rising edge
//  rst_n         in   1      asynchronous, active-low reset
//  start         in   1      pulse: leave IDLE, begin fetching at RESET_PC
//  imem_req      out  1      instruction fetch request
//  imem_addr     out  PC_W   fetch address (= pc)
//  imem_ready    in   1      fetch data valid this cycle
//  imem_rdata    in   16     fetched instruction
//  ir            out  16     instruction register, to decoder
//  dec_regwrite  in   1      decoder RegWrite
//  dec_memwrite  in   1      decoder MemWrite
//  dec_memtoreg  in   1      decoder MemToReg (load)
//  alu_zero      in   1      ALU result == 0
//  dmem_req      out  1      data memory request
//  dmem_we       out  1      data memory write strobe (qualified by dmem_req)
//  dmem_ready    in   1      data memory access complete
//  rf_we         out  1      gated register-file write enable
//  pc            out  PC_W   program counter
//  halted        out  1      core stopped in HALT
//  trap          out  1      illegal opcode trapped (only with SEQ_ILLEGAL_TRAP_EN)
//  retired       out  CNT_W  instructions retired, saturates at all-ones
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, pc=RESET_PC, ir=0, retired=0.
//   All request/strobe outputs, halted and trap are 0. Any in-flight memory access is abandoned.
//  States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT (TRAP only with the macro).
//  IDLE: waits for start=1, then goes to FETCH. start is ignored in every other state.
//  FETCH: imem_req=1 held until imem_ready=1 is sampled.
//   On that edge: ir<=imem_rdata, pc<=pc+1 (wraps mod 2^PC_W), go to DECODE.
//  DECODE: one cycle for decoder outputs to settle on ir, then EXEC.
//  EXEC: one cycle. Opcode selects the next step:
//   1111: go to HALT.
//   1011 (BEQ) / 1100 (BNE): taken when alu_zero=1 / alu_zero=0 respectively.
//    Taken branch: pc<=pc+sext(ir[7:0]) (relative to the incremented pc). Then FETCH.
//   0000 (load) or 0001 (store): go to MEM.
//   Any other opcode: go to WB.
//  MEM: dmem_req=1 and dmem_we=dec_memwrite, both held until dmem_ready=1 is sampled.
//   Store then goes to FETCH; load (dec_memtoreg=1) goes to WB.
//  WB: rf_we=dec_regwrite for exactly one cycle, then FETCH.
//  Retire: retired increments (saturating) on the last cycle of each instruction:
//   WB, a store's MEM completion, or a branch's EXEC. HALT itself is not counted.
//  HALT: halted=1, no requests issued. Exit only via reset.
//  imem_ready/dmem_ready are ignored outside FETCH/MEM. Late or unsolicited readies have no effect.
//  Latency with zero-wait memories: ALU op 4 cycles, load 5, store 4, branch 3.
// CONFIGURATION
//  SEQ_ILLEGAL_TRAP_EN defined: opcode 1110 in EXEC goes to TRAP.
//   TRAP: trap=1 and halted=1, pc frozen at the faulting pc+1, not retired, exit only via reset.
//  SEQ_ILLEGAL_TRAP_EN undefined: 1110 executes as a NOP (EXEC->WB).
//   The decoder already drives RegWrite=0 for 1110, so no register is written. It is retired.
//   trap is tied to 0.
// STRUCTURE
//  cpu_pkg: opcode localparams (OP_LOAD=0000, OP_STORE=0001, OP_BEQ=1011, OP_BNE=1100,
//   OP_ILL=1110, OP_HALT=1111) and state encoding constants.
//  One sub-module: seq_pc_unit.
//   Holds the PC register, the +1 incrementer and the sign-extended branch adder.
//   Controls: load_reset, inc, branch.
//  FSM, IR and retire counter live in cpu_sequencer.
// TESTING
//  Zero-wait memories, program {3001, F000}, start pulse:
//   -> rf_we high exactly one cycle, on cycle 4 after FETCH entry; halted=1; retired=1; pc=2.
//  Load 0005 with dmem_ready delayed 3 cycles:
//   -> dmem_req high 4 cycles, dmem_we=0; rf_we 1 cycle after ready; retired +1.
//  Store 1003:
//   -> dmem_req/dmem_we high until ready; rf_we never asserted; next FETCH follows immediately.
//  BEQ B0FE at pc=4 with alu_zero=1 -> next imem_addr=3.
//   Same with alu_zero=0 -> next imem_addr=5.
//   BNE C002 with alu_zero=0 -> next imem_addr=pc+3.
//  rst_n low mid-MEM with dmem_req=1:
//   -> dmem_req drops asynchronously; IDLE, pc=RESET_PC, retired=0.
//   A dmem_ready arriving after release is ignored.
//  Opcode E000:
//   -> with macro: trap=1, halted=1, retired unchanged.
//   -> without macro: no rf_we, retired +1, fetch continues at pc+1.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the 16-bit core's control sequencer.
//   - opcode constants that the sequencer decodes directly
//   - sequencer state encoding, which is also exported on the debug port
//   - sext8: sign-extends an 8-bit branch offset to 16 bits
package cpu_pkg;

    localparam logic [3:0] OP_LOAD  = 4'b0000;
    localparam logic [3:0] OP_STORE = 4'b0001;
    localparam logic [3:0] OP_BEQ   = 4'b1011;
    localparam logic [3:0] OP_BNE   = 4'b1100;
    localparam logic [3:0] OP_ILL   = 4'b1110;
    localparam logic [3:0] OP_HALT  = 4'b1111;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6,
        ST_TRAP   = 3'd7
    } seq_state_e;

    function automatic logic [15:0] sext8(input logic [7:0] v);
        return {{8{v[7]}}, v};
    endfunction

endpackage

// File: rtl/cpu_sequencer_pc_unit.sv
// seq_pc_unit: program counter register with its +1 incrementer and the
// sign-extended relative branch adder.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset (pc <= RESET_PC)
//   load_reset   load RESET_PC (start of a program)
//   inc          pc <= pc + 1, wrapping modulo 2^PC_W
//   branch       pc <= pc + sext(br_off), wrapping modulo 2^PC_W
//   br_off       8-bit signed branch offset
//   pc           current program counter
// Controls are prioritised load_reset > inc > branch; the sequencer never
// asserts more than one in a cycle. PC_W must lie between 8 and 16.
module seq_pc_unit
    import cpu_pkg::*;
#(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load_reset,
    input  logic            inc,
    input  logic            branch,
    input  logic [7:0]      br_off,
    output logic [PC_W-1:0] pc
);

    logic [PC_W-1:0] pc_q, pc_d;
    logic [15:0]     off_ext;

    assign off_ext = sext8(br_off);

    always_comb begin
        pc_d = pc_q;
        if (load_reset) begin
            pc_d = RESET_PC;
        end else if (inc) begin
            pc_d = pc_q + PC_W'(1);
        end else if (branch) begin
            // Truncating the 16-bit extension keeps the add modulo 2^PC_W.
            pc_d = pc_q + off_ext[PC_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle control FSM of the 16-bit core.
// Fetches into the IR, sequences DECODE/EXEC/MEM/WB, gates decoder
// RegWrite/MemWrite to once per instruction, resolves BEQ/BNE, handles halt
// and counts retired instructions (saturating).
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   start                             leave IDLE and fetch from RESET_PC
//   imem_req/imem_addr/imem_ready/imem_rdata   instruction fetch
//   ir                                instruction register, to the decoder
//   dec_regwrite/dec_memwrite/dec_memtoreg     decoder controls
//   alu_zero                          ALU result is zero (branch condition)
//   dmem_req/dmem_we/dmem_ready       data memory access
//   rf_we                             gated register-file write enable
//   pc, halted, trap, retired         status
//   dbg_state                         current FSM state
// Handshake: a request (imem_req/dmem_req) is raised on entering FETCH/MEM
// and held; the access completes on the first rising edge where the request
// is high and the matching ready is sampled high. A ready seen while no
// request is raised is ignored.
// Build option: SEQ_ILLEGAL_TRAP_EN makes opcode 1110 trap (TRAP state);
// without it 1110 retires as a NOP through WB and trap stays 0.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             imem_req,
    output logic [PC_W-1:0]  imem_addr,
    input  logic             imem_ready,
    input  logic [15:0]      imem_rdata,
    output logic [15:0]      ir,
    input  logic             dec_regwrite,
    input  logic             dec_memwrite,
    input  logic             dec_memtoreg,
    input  logic             alu_zero,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ready,
    output logic             rf_we,
    output logic [PC_W-1:0]  pc,
    output logic             halted,
    output logic             trap,
    output logic [CNT_W-1:0] retired,
    output seq_state_e       dbg_state
);

    seq_state_e       state_q, state_d;
    logic [15:0]      ir_q, ir_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             retire;
    logic             pc_load, pc_inc, pc_branch;
    logic [3:0]       opcode;
    logic             br_taken;

    assign opcode   = ir_q[15:12];
    assign br_taken = (opcode == OP_BEQ) ? alu_zero : ~alu_zero;

    seq_pc_unit #(
        .PC_W     (PC_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_reset (pc_load),
        .inc        (pc_inc),
        .branch     (pc_branch),
        .br_off     (ir_q[7:0]),
        .pc         (pc)
    );

    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        retire    = 1'b0;
        pc_load   = 1'b0;
        pc_inc    = 1'b0;
        pc_branch = 1'b0;
        imem_req  = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        rf_we     = 1'b0;
        halted    = 1'b0;
        trap      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    pc_load = 1'b1;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_d    = imem_rdata;
                    pc_inc  = 1'b1;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: state_d = ST_EXEC;
            ST_EXEC: begin
                case (opcode)
                    OP_HALT: state_d = ST_HALT;
                    OP_BEQ, OP_BNE: begin
                        // Offset is relative to the already-incremented pc.
                        pc_branch = br_taken;
                        retire    = 1'b1;
                        state_d   = ST_FETCH;
                    end
                    OP_LOAD, OP_STORE: state_d = ST_MEM;
`ifdef SEQ_ILLEGAL_TRAP_EN
                    OP_ILL: state_d = ST_TRAP;
`else
                    // Retires as a NOP; the decoder holds RegWrite low for it.
                    OP_ILL: state_d = ST_WB;
`endif
                    default: state_d = ST_WB;
                endcase
            end
            ST_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = dec_memwrite;
                if (dmem_ready) begin
                    if (dec_memtoreg) begin
                        state_d = ST_WB;
                    end else begin
                        retire  = 1'b1;
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_WB: begin
                rf_we   = dec_regwrite;
                retire  = 1'b1;
                state_d = ST_FETCH;
            end
            ST_HALT: halted = 1'b1;
            ST_TRAP: begin
`ifdef SEQ_ILLEGAL_TRAP_EN
                halted = 1'b1;
                trap   = 1'b1;
`else
                state_d = ST_IDLE;
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        retired_d = retired_q;
        if (retire && (retired_q != {CNT_W{1'b1}})) begin
            retired_d = retired_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            ir_q      <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            retired_q <= retired_d;
        end
    end

    assign imem_addr = pc;
    assign ir        = ir_q;
    assign retired   = retired_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer. An instruction-level reference model turns each
// fetched instruction into its expected per-cycle outputs plus the inputs the
// bench drives in those cycles (memory wait states, alu_zero, stray readies).
module tb_cpu_sequencer;
  import cpu_pkg::*;

  localparam int PC_W = 10;
  localparam logic [PC_W-1:0] RP = 10'h3FC;
  localparam int CW = 4;
  localparam int MEM_N = 1 << PC_W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic imem_ready = 1'b0;
  logic [15:0] imem_rdata = '0;
  logic alu_zero = 1'b0;
  logic dmem_ready = 1'b0;
  logic dec_regwrite, dec_memwrite, dec_memtoreg;
  logic imem_req, dmem_req, dmem_we, rf_we, halted, trap;
  logic [PC_W-1:0] imem_addr, pc;
  logic [15:0] ir;
  logic [CW-1:0] retired;
  logic [2:0] dbg_state;

  cpu_sequencer #(.PC_W(PC_W), .RESET_PC(RP), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .ir(ir), .dec_regwrite(dec_regwrite), .dec_memwrite(dec_memwrite), .dec_memtoreg(dec_memtoreg),
    .alu_zero(alu_zero), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
    .rf_we(rf_we), .pc(pc), .halted(halted), .trap(trap), .retired(retired), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // decoder stand-in
  function automatic logic regwrite_of(input logic [3:0] op);
    return !(op == OP_STORE || op == OP_BEQ || op == OP_BNE || op == OP_HALT || op == OP_ILL);
  endfunction
  assign dec_regwrite = regwrite_of(ir[15:12]);
  assign dec_memwrite = (ir[15:12] == OP_STORE);
  assign dec_memtoreg = (ir[15:12] == OP_LOAD);

  typedef struct {
    logic start; logic imem_ready; logic [15:0] rdata; logic dmem_ready; logic alu_zero;
    logic e_imem_req; logic [PC_W-1:0] e_pc; logic e_dmem_req; logic e_dmem_we; logic e_rf_we;
    logic e_halted; logic e_trap; logic [15:0] e_ir; logic [CW-1:0] e_ret;
  } cyc_t;

  // reference model state
  logic [15:0] prog [0:MEM_N-1];
  logic [PC_W-1:0] m_pc;
  logic [15:0] m_ir;
  logic [CW-1:0] m_ret;
  int m_mode;  // 0 idle, 1 running, 2 halted, 3 trapped
  cyc_t q[$];
  int imem_wmax, dmem_wfix, az_fix, idle_wmax;

  // scoreboard / logs
  int n_vec = 0;
  int n_err = 0;
  int cyc_idx, rf_cnt, rf_at, dm_cnt, we_cnt;
  int fetch_log[$];
  int fetch_at[$];
  logic last_mem;

  task automatic report_and_finish();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d, state %0d)", nm, act, exp, cyc_idx, dbg_state);
    end
  endtask

  function automatic cyc_t base_rec();
    cyc_t r;
    r.start = 1'($urandom_range(0, 1));
    r.imem_ready = 1'($urandom_range(0, 1));
    r.rdata = 16'($urandom);
    r.dmem_ready = 1'($urandom_range(0, 1));
    r.alu_zero = 1'($urandom_range(0, 1));
    r.e_imem_req = 1'b0; r.e_dmem_req = 1'b0; r.e_dmem_we = 1'b0; r.e_rf_we = 1'b0;
    r.e_pc = m_pc; r.e_ir = m_ir; r.e_ret = m_ret;
    r.e_halted = (m_mode >= 2);
    r.e_trap = (m_mode == 3);
    return r;
  endfunction

  task automatic model_reset();
    m_pc = RP; m_ir = '0; m_ret = '0; m_mode = 0;
    q.delete();
  endtask

  task automatic retire_one();
    if (int'(m_ret) < (1 << CW) - 1) m_ret = CW'(int'(m_ret) + 1);
  endtask

  // Expands the next instruction (or idle/halt cycle) into per-cycle records.
  task automatic model_step();
    cyc_t r;
    int w;
    logic [15:0] instr;
    logic [3:0] op;
    logic az, taken;
    if (m_mode == 0) begin
      w = $urandom_range(0, idle_wmax);
      for (int k = 0; k < w; k++) begin
        r = base_rec(); r.start = 1'b0; q.push_back(r);
      end
      r = base_rec(); r.start = 1'b1; q.push_back(r);
      m_mode = 1;
      return;
    end
    if (m_mode >= 2) begin
      q.push_back(base_rec());
      return;
    end
    instr = prog[m_pc];
    w = $urandom_range(0, imem_wmax);
    for (int k = 0; k <= w; k++) begin
      r = base_rec(); r.e_imem_req = 1'b1; r.imem_ready = (k == w);
      if (k == w) r.rdata = instr;
      q.push_back(r);
    end
    m_ir = instr;
    m_pc = PC_W'(int'(m_pc) + 1);
    q.push_back(base_rec());                       // decode
    az = (az_fix >= 0) ? 1'(az_fix) : 1'($urandom_range(0, 1));
    r = base_rec(); r.alu_zero = az; q.push_back(r); // execute
    op = instr[15:12];
    if (op == OP_HALT) begin m_mode = 2; return; end
`ifdef SEQ_ILLEGAL_TRAP_EN
    if (op == OP_ILL) begin m_mode = 3; return; end
`endif
    if (op == OP_BEQ || op == OP_BNE) begin
      taken = (op == OP_BEQ) ? az : !az;
      if (taken) m_pc = PC_W'(int'(m_pc) + int'($signed(instr[7:0])));
      retire_one();
      return;
    end
    if (op == OP_LOAD || op == OP_STORE) begin
      w = (dmem_wfix >= 0) ? dmem_wfix : $urandom_range(0, 3);
      for (int k = 0; k <= w; k++) begin
        r = base_rec(); r.e_dmem_req = 1'b1; r.e_dmem_we = (op == OP_STORE); r.dmem_ready = (k == w);
        q.push_back(r);
      end
      if (op == OP_STORE) begin retire_one(); return; end
    end
    r = base_rec(); r.e_rf_we = regwrite_of(op); q.push_back(r);
    retire_one();
  endtask

  task automatic check_cycle(input cyc_t r);
    chk("imem_req", imem_req, r.e_imem_req);
    chk("imem_addr", imem_addr, r.e_pc);
    chk("pc", pc, r.e_pc);
    chk("dmem_req", dmem_req, r.e_dmem_req);
    chk("dmem_we", dmem_req & dmem_we, r.e_dmem_req & r.e_dmem_we);
    chk("rf_we", rf_we, r.e_rf_we);
    chk("halted", halted, r.e_halted);
    chk("trap", trap, r.e_trap);
    chk("ir", ir, r.e_ir);
    chk("retired", retired, r.e_ret);
  endtask

  task automatic clear_logs();
    cyc_idx = 0; rf_cnt = 0; rf_at = -1; dm_cnt = 0; we_cnt = 0; last_mem = 1'b0;
    fetch_log.delete(); fetch_at.delete();
  endtask

  // driver: one record per clock, inputs after the rising edge, checks on the falling edge
  task automatic run(input int n);
    cyc_t r;
    for (int i = 0; i < n; i++) begin
      if (q.size() == 0) model_step();
      r = q.pop_front();
      @(posedge clk); #1;
      start = r.start; imem_ready = r.imem_ready; imem_rdata = r.rdata;
      dmem_ready = r.dmem_ready; alu_zero = r.alu_zero;
      @(negedge clk);
      check_cycle(r);
      if (rf_we) begin rf_cnt++; rf_at = cyc_idx; end
      if (dmem_req) dm_cnt++;
      if (dmem_req && dmem_we) we_cnt++;
      if (imem_req && r.imem_ready) begin fetch_log.push_back(int'(imem_addr)); fetch_at.push_back(cyc_idx); end
      last_mem = r.e_dmem_req;
      cyc_idx++;
      if (n_err >= 40) report_and_finish();
    end
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_imem_req"}, imem_req, 0);
    chk({tag, "_dmem_req"}, dmem_req, 0);
    chk({tag, "_dmem_we"}, dmem_we, 0);
    chk({tag, "_rf_we"}, rf_we, 0);
    chk({tag, "_halted"}, halted, 0);
    chk({tag, "_trap"}, trap, 0);
    chk({tag, "_pc"}, pc, 32'h3FC);
    chk({tag, "_ir"}, ir, 0);
    chk({tag, "_retired"}, retired, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; start = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
    #1 check_reset_values("rst");
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    clear_logs();
  endtask

  // Called on a falling edge: reset lands mid-cycle, then late readies follow.
  task automatic async_reset_now(input string tag);
    #2 rst_n = 1'b0;
    #1 check_reset_values(tag);
    @(posedge clk); #1;
    dmem_ready = 1'b1; imem_ready = 1'b1; start = 1'b0;
    rst_n = 1'b1;
    model_reset();
    clear_logs();
  endtask

  task automatic fill_prog(input logic [15:0] w);
    for (int a = 0; a < MEM_N; a++) prog[a] = w;
  endtask

  task automatic put(input int off, input logic [15:0] w);
    prog[PC_W'(int'(RP) + off)] = w;
  endtask

  function automatic int fl(input int i);
    return (fetch_log.size() > i) ? fetch_log[i] : -1;
  endfunction

  function automatic int fa(input int i);
    return (fetch_at.size() > i) ? fetch_at[i] : -1;
  endfunction

  task automatic directed_knobs(input int dm_wait, input int az);
    imem_wmax = 0; dmem_wfix = dm_wait; az_fix = az; idle_wmax = 0;
  endtask

  initial begin
    int op;
    model_reset();
    clear_logs();

    // ALU op then halt, zero-wait
    directed_knobs(0, -1);
    fill_prog(16'hF000); put(0, 16'h3001); put(1, 16'hF000);
    do_reset(); run(12);
    chk("t1_rf_we_count", rf_cnt, 1);
    chk("t1_rf_we_cycle", rf_at, 4);
    chk("t1_halted", halted, 1);
    chk("t1_retired", retired, 1);
    chk("t1_pc", pc, 32'h3FE);

    // load with three wait cycles
    directed_knobs(3, -1);
    fill_prog(16'hF000); put(0, 16'h0005);
    do_reset(); run(16);
    chk("t2_dmem_req_cycles", dm_cnt, 4);
    chk("t2_dmem_we_cycles", we_cnt, 0);
    chk("t2_rf_we_count", rf_cnt, 1);
    chk("t2_rf_we_cycle", rf_at, 8);
    chk("t2_retired", retired, 1);

    // store with two wait cycles
    directed_knobs(2, -1);
    fill_prog(16'hF000); put(0, 16'h1003);
    do_reset(); run(14);
    chk("t3_dmem_req_cycles", dm_cnt, 3);
    chk("t3_dmem_we_cycles", we_cnt, 3);
    chk("t3_rf_we_count", rf_cnt, 0);
    chk("t3_next_fetch_cycle", fa(1), 7);
    chk("t3_retired", retired, 1);

    // branches at RESET_PC+4 (pc wraps to 0 there)
    for (int t = 0; t < 3; t++) begin
      directed_knobs(0, (t == 0) ? 1 : 0);
      fill_prog(16'hF000);
      for (int i = 0; i < 4; i++) put(i, 16'h2000);
      put(4, (t == 2) ? 16'hC002 : 16'hB0FE);
      do_reset(); run(30);
      chk("t4_branch_target", fl(5), (t == 0) ? 32'h3FF : (t == 1) ? 32'h001 : 32'h003);
    end

    // async reset while a load waits on data memory
    directed_knobs(6, -1);
    fill_prog(16'hF000); put(0, 16'h2000); put(1, 16'h0005);
    do_reset();
    for (int k = 0; k < 40 && !last_mem; k++) run(1);
    chk("t5_in_mem_before_reset", dmem_req, 1);
    chk("t5_retired_before_reset", retired, 1);
    async_reset_now("t5");
    run(12);

    // opcode 1110
    directed_knobs(0, -1);
    fill_prog(16'hF000); put(0, 16'hE000); put(1, 16'hF000);
    do_reset(); run(14);
`ifdef SEQ_ILLEGAL_TRAP_EN
    chk("t6_trap", trap, 1);
    chk("t6_halted", halted, 1);
    chk("t6_retired", retired, 0);
    chk("t6_pc", pc, 32'h3FD);
`else
    chk("t6_rf_we_count", rf_cnt, 0);
    chk("t6_retired", retired, 1);
    chk("t6_next_fetch", fl(1), 32'h3FD);
`endif

    // retire counter saturation
    directed_knobs(0, -1);
    fill_prog(16'hF000);
    for (int i = 0; i < 20; i++) put(i, 16'h2000);
    do_reset(); run(100);
    chk("t7_retired_saturated", retired, 15);
    chk("t7_halted", halted, 1);

    // random programs, wait states and stray readies
    for (int ep = 0; ep < 25; ep++) begin
      imem_wmax = 2; dmem_wfix = -1; az_fix = -1; idle_wmax = 2;
      for (int a = 0; a < MEM_N; a++) begin
        op = $urandom_range(0, 15);
        if (op == 15 && $urandom_range(0, 3) != 0) op = 2;
        prog[a] = {4'(op), 12'($urandom)};
      end
      do_reset();
      run($urandom_range(80, 200));
      if (ep % 3 == 0) begin
        async_reset_now("rnd_rst");
        run(40);
      end
    end

    report_and_finish();
  end

  initial begin
    #1000000;
    n_err++;
    $display("FAIL watchdog: got timeout, want completion");
    report_and_finish();
  end

endmodule
